// File: rtl/mux_disp_pkg.sv
// rtl/mux_disp_pkg.sv - shared types and glyph table for the multiplexed display scanner
// Purpose: segment type, blank pattern, scan state enum and active-low hex glyphs.
// Ports: none (package).
package mux_disp_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  typedef enum logic {BLANK, DRIVE} scan_state_e;

  // Indexed by nibble value; element 0 is the rightmost entry.
  localparam seg7_t [15:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low seven-segment decoder
// Purpose: full 0-F hex glyph lookup.
// Ports: nib_i  - 4-bit value
//        seg_o  - segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import mux_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  assign seg_o = HEX_GLYPH[nib_i];

endmodule

// File: rtl/mux_disp_scanner.sv
// rtl/mux_disp_scanner.sv - time-multiplexed common-anode hex display scanner
// Purpose: snapshots D at frame boundaries and scans it digit by digit with a
//          blanking gap at the start of every digit slot.
// Optional feature: MUX_DISP_LZB_EN enables leading-zero blanking.
// Ports: CLK      - clock
//        RST      - synchronous active-high reset
//        D        - value to display, D[3:0] is digit 0 (rightmost)
//        LOAD     - request a snapshot of D at the next frame boundary
//        DP_MASK  - per-digit decimal point enable, sampled live
//        AN       - anode enables, active-low
//        SEG      - segments {g,f,e,d,c,b,a}, active-low
//        DP       - decimal point, active-low
//        FRAME    - one-cycle pulse at the start of each new frame
module mux_disp_scanner
  import mux_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  LOAD,
  input  logic [DIGITS-1:0]     DP_MASK,
  output logic [DIGITS-1:0]     AN,
  output seg7_t                 SEG,
  output logic                  DP,
  output logic                  FRAME
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic                pend_q, pend_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg7_t               seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_q, frame_d;

  logic                wrap, boundary;
  scan_state_e         state_d;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                drive_an;
  seg7_t               glyph;

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (nib),
    .seg_o (glyph)
  );

  // Counters and snapshot.
  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == IDX_MAX);

    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    // LOAD on the boundary edge itself is consumed directly, so pend never
    // survives a boundary.
    snap_d = snap_q;
    pend_d = pend_q | LOAD;
    if (boundary) begin
      if (pend_q || LOAD) begin
        snap_d = D;
      end
      pend_d = 1'b0;
    end

    // The reset state is itself (0,0), so only a real wrap raises FRAME;
    // this keeps the first frame after reset silent.
    frame_d = boundary;
  end

  // Outputs are computed from next-state values and registered, so they line
  // up with the (cnt, idx) held in the same cycle.
  always_comb begin
    state_d = (cnt_d < BLANK_LIM) ? BLANK : DRIVE;

    nib    = '0;
    dp_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib    = snap_d[4*i +: 4];
        dp_bit = DP_MASK[i];
      end
    end

    an_d     = '1;
    seg_d    = SEG_OFF;
    dp_d     = 1'b1;
    drive_an = 1'b1;

    if (state_d == DRIVE) begin
      dp_d  = ~dp_bit;
      seg_d = glyph;
`ifdef MUX_DISP_LZB_EN
      // Digits above the highest nonzero nibble are dark; the anode stays on
      // only to show a lit decimal point. Digit 0 is never above hi.
      begin
        logic [IDX_W-1:0] hi;
        hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
          if (snap_d[4*i +: 4] != 4'h0) begin
            hi = IDX_W'(i);
          end
        end
        if (idx_d > hi) begin
          seg_d    = SEG_OFF;
          drive_an = dp_bit;
        end
      end
`else
      drive_an = 1'b1;
`endif
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_d[i] = ~drive_an;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign FRAME = frame_q;

endmodule
